// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver/FIFO and its consumer.
// The master side drives the serial line and the pop request; the slave side
// (the receiver) returns the FIFO head, its status and the error pulses.
interface uart_rx_fifo_if;
  logic       uart_dataH;
  logic       rd_ackH;
  logic [7:0] rd_dataH;
  logic       rd_validH;
  logic [2:0] fifo_cntH;
  logic       frame_errH;
  logic       overrun_errH;
  logic       busyH;

  modport master (
    output uart_dataH, rd_ackH,
    input  rd_dataH, rd_validH, fifo_cntH, frame_errH, overrun_errH, busyH
  );

  modport slave (
    input  uart_dataH, rd_ackH,
    output rd_dataH, rd_validH, fifo_cntH, frame_errH, overrun_errH, busyH
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 16 clocks per bit) feeding a 4-entry receive FIFO.
// Start bit is qualified at mid-bit, data and stop bits are sampled at the
// end of each 16-cycle cell measured from that mid-start point.
module uart_rx_fifo (
  input  logic          sys_clk,
  input  logic          sys_rst_l,
  uart_rx_fifo_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0] sync_q, sync_d;
  logic       rx;
  logic [2:0] state_q, state_d;
  logic [3:0] cell_q, cell_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       push_req;

  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_pop, do_push, full;

  // Two-flop synchronizer; the FSM only ever looks at the second stage.
  always_comb begin
    sync_d = {sync_q[0], bus.uart_dataH};
  end

  assign rx = sync_q[1];

  // Receive FSM: start qualification, bit sampling and stop-bit check.
  always_comb begin
    state_d     = state_q;
    cell_d      = cell_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d = S_START;
          cell_d  = 4'd0;
        end
      end
      S_START: begin
        if (cell_q == 4'd7) begin
          if (!rx) begin
            state_d = S_DATA;
            cell_d  = 4'd0;
            bit_d   = 4'd0;
          end else begin
            // Low pulse shorter than half a bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cell_d = cell_q + 4'd1;
        end
      end
      S_DATA: begin
        if (cell_q == 4'd15) begin
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
          cell_d  = 4'd0;
          if (bit_q == 4'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cell_d = cell_q + 4'd1;
        end
      end
      S_STOP: begin
        if (cell_q == 4'd15) begin
          cell_d = 4'd0;
          if (rx) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cell_d = cell_q + 4'd1;
        end
      end
      S_BREAK: begin
        // Wait for the line to return high before looking for a new start.
        if (rx) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO control: a pop frees a slot in the same edge, so a push into a full
  // FIFO is accepted whenever it coincides with a pop.
  always_comb begin
    full      = (cnt_q == 3'd4);
    do_pop    = bus.rd_ackH && (cnt_q != 3'd0);
    do_push   = push_req && (!full || do_pop);
    overrun_d = push_req && full && !do_pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage write: the completed shift register lands at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = shift_q;
    end
  end

  // Control and receiver state, synchronously reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      cell_q      <= 4'd0;
      bit_q       <= 4'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      cnt_q       <= 3'd0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cell_q      <= cell_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // FIFO storage is not reset; the count gates every read of it.
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
  end

  assign bus.rd_dataH     = (cnt_q == 3'd0) ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.rd_validH    = (cnt_q != 3'd0);
  assign bus.fifo_cntH    = cnt_q;
  assign bus.frame_errH   = frame_err_q;
  assign bus.overrun_errH = overrun_q;
  assign bus.busyH        = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameters: none; bit cell fixed at 16 sys_clk cycles, FIFO depth fixed at 4 entries.
REQ-002 sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 sys_rst_l  input  1  reset, synchronous, active-low.
REQ-004 uart_dataH  input  1  serial line from remote transmitter; idle high; asynchronous to sys_clk.
REQ-005 rd_ackH  input  1  consumer pop request; ignored when FIFO empty.
REQ-006 rd_dataH  output  8  byte at FIFO head; 8'h00 when empty.
REQ-007 rd_validH  output  1  FIFO non-empty.
REQ-008 fifo_cntH  output  3  entries held, 0..4.
REQ-009 frame_errH  output  1  one-cycle pulse on bad stop bit.
REQ-010 overrun_errH  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
REQ-011 busyH  output  1  high whenever the receive FSM is not in IDLE.

Function
REQ-012 uart_dataH SHALL pass through a 2-flop synchronizer, reset value 1; the FSM uses only the second flop (rxH).
REQ-013 Frame format SHALL be: start bit low, 8 data bits LSB first, 1 stop bit high, no parity, each bit 16 cycles.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; a 4-bit cell counter and a 4-bit bit counter SHALL support the FSM.
REQ-015 IDLE: if rxH==0, go to START and clear the cell counter; otherwise stay.
REQ-016 START: at cell count 7, if rxH==0 go to DATA and clear both counters; if rxH==1 return to IDLE (glitch reject); otherwise increment the cell counter.
REQ-017 DATA: at cell count 15, shift rxH into the shift register MSB, shift the register right, increment the bit counter, and clear the cell counter.
REQ-018 DATA: after the 8th sample, go to STOP.
REQ-019 STOP: at cell count 15, sample rxH.
REQ-020 STOP sample ==1: push the shift register into the FIFO and go to IDLE.
REQ-021 STOP sample ==0: pulse frame_errH, discard the byte, and go to BREAK.
REQ-022 BREAK: stay until rxH==1, then go to IDLE; no start detection occurs in BREAK.
REQ-023 Push and pop SHALL take effect on the same edge as the sampling or ack; rd_validH and fifo_cntH reflect the new count on the following cycle.
REQ-024 Pop: rd_ackH && rd_validH SHALL remove the head; rd_dataH then shows the next entry, or 8'h00 if the FIFO is now empty.
REQ-025 Push when full without a same-cycle pop: the byte SHALL be dropped, overrun_errH pulsed, and FIFO contents unchanged.
REQ-026 Push when full with a same-cycle pop: both SHALL take effect, count stays 4, and there is no overrun.
REQ-027 Simultaneous push and pop at count 1..3: count SHALL be unchanged and order preserved.
REQ-028 Read and write pointers SHALL be 2 bits and wrap 3->0; count is tracked separately, so full and empty are never ambiguous.
REQ-029 Latency: a clean frame whose first low on uart_dataH is captured at edge E0 SHALL push at edge E0+154; rd_validH is high in the cycle after that edge.
REQ-030 Back-to-back frames (stop bit immediately followed by a start bit) SHALL be received without loss.

Reset
REQ-031 While sys_rst_l==0 at a rising edge, the following SHALL be cleared or set:
- FSM = IDLE; counters = 0; shift register = 0
- FIFO pointers and count = 0; synchronizer flops = 1
- rd_validH, frame_errH, overrun_errH, busyH = 0; rd_dataH = 8'h00
REQ-032 Reset asserted mid-frame SHALL abort the frame with no push and no error pulse, and leave FIFO contents discarded.
REQ-033 Outputs SHALL be undefined-free (no X) from the first edge with reset low.

Verification
REQ-034 Single frame 8'hA5 at 16 cycles/bit -> rd_validH rises at E0+155, rd_dataH=8'hA5, fifo_cntH=1; rd_ackH one cycle -> rd_validH=0, rd_dataH=8'h00.
REQ-035 Line low for 5 cycles only -> FSM returns to IDLE, no push, no error, busyH deasserts.
REQ-036 Frame 8'h3C with stop bit held low for 40 cycles -> frame_errH one pulse, fifo_cntH=0, no new start accepted until the line goes high.
REQ-037 Five back-to-back frames 8'h01..8'h05 with no reads -> fifo_cntH=4, overrun_errH pulses once on the 5th frame; reads return 01,02,03,04.
REQ-038 FIFO full with rd_ackH asserted on the 5th frame's push edge -> no overrun, count stays 4, reads return 02,03,04,05.
REQ-039 sys_rst_l pulsed low during DATA of a frame, with 2 entries held -> all outputs return to reset values; the next clean frame is received correctly.
